uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx_sol` transmitter among N byte-producing requesters inside `top`. It accepts one byte per grant, drives the transmitter's `en`/`data_in` handshake against its `rdy`, and returns a one-cycle acknowledge to the winning requester. It sits between the design's message sources (status reporter, echo path, debug dump) and the single TX pin.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte producers.
// Optional grant locking is compiled in with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_lock,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           tx_en,
  output logic [7:0]     tx_data,
  input  logic           tx_rdy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     ack_q, ack_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [7:0]       req_bytes [N];
  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] win_idx;
  logic             lock_hit;

  for (genvar i = 0; i < N; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  // Walk from farthest to nearest so the first requester after ptr wins.
  always_comb begin
    rr_idx = ptr_q;
    cand   = ptr_q;
    for (int k = N; k >= 1; k--) begin
      cand = PTR_W'((int'(ptr_q) + k) % N);
      if (req[cand]) begin
        rr_idx = cand;
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // Lock is sampled when the owner's byte is taken and dropped once the
  // owner stops requesting; a locked re-grant leaves ptr where it is.
  always_comb begin
    lock_d = lock_q;
    if (state_q == ISSUE && !tx_rdy) begin
      lock_d = |(req_lock & grant_q);
    end else if (state_q == IDLE && !req[ptr_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock_hit = lock_q && req[ptr_q];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_hit    = 1'b0;
`endif

  assign win_idx = lock_hit ? ptr_q : rr_idx;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (tx_rdy && (req != '0)) begin
          tx_data_d = req_bytes[win_idx];
          grant_d   = N'(1) << win_idx;
          tx_en_d   = 1'b1;
          ptr_d     = win_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_rdy) begin
          tx_en_d = 1'b0;
          ack_d   = grant_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tx_rdy) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ack     = ack_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural transmitter and requesters,
// byte order and handshake timing checked against hand-computed sequences.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int TX_BUSY = 5;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic           tx_rdy;

  int vecCount  = 0;
  int missCount = 0;

  logic [7:0] rqBytes [4][4];
  int         rqCnt   [4];
  int         rqPos   [4];
  logic       rqLock  [4];
  int         ackCnt  [4];

  logic [7:0] sent [$];
  int         txCnt;
  logic       rdyHoldLow;
  int         onehotErr;

  uart_tx_arbiter #(.N(N), .PTR_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_lock (req_lock),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input int n, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2, input logic lk);
    rqBytes[idx][0] = b0;
    rqBytes[idx][1] = b1;
    rqBytes[idx][2] = b2;
    rqBytes[idx][3] = 8'h00;
    rqPos[idx]      = 0;
    rqCnt[idx]      = n;
    rqLock[idx]     = lk;
  endtask

  task automatic resetScore();
    for (int i = 0; i < 4; i++) ackCnt[i] = 0;
    sent.delete();
  endtask

  function automatic bit allConsumed();
    for (int i = 0; i < 4; i++) begin
      if (rqPos[i] < rqCnt[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic waitDrain(input string tag, input int maxCycles);
    bit done = 1'b0;
    for (int c = 0; c < maxCycles && !done; c++) begin
      @(posedge clk); #1;
      done = allConsumed() && !busy && tx_rdy && (txCnt == 0);
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic checkSent(input string tag, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] expB [4];
    expB = '{e0, e1, e2, e3};
    checkOutput({tag, "_len"}, 32'(sent.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s_%0d", tag, k),
                  (k < sent.size()) ? 32'(sent[k]) : 32'hFFFF_FFFF, 32'(expB[k]));
    end
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requesters: hold each byte until its ack, then present the next or drop req.
  initial begin
    req      = '0;
    req_data = '0;
    req_lock = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          ackCnt[i]++;
          rqPos[i]++;
        end
        req[i]             = (rqPos[i] < rqCnt[i]);
        req_data[8*i +: 8] = (rqPos[i] < rqCnt[i]) ? rqBytes[i][rqPos[i]] : 8'h00;
        req_lock[i]        = rqLock[i];
      end
    end
  end

  // Transmitter: accepts a byte when en and rdy meet, then stays busy TX_BUSY cycles.
  initial begin
    tx_rdy    = 1'b1;
    txCnt     = 0;
    onehotErr = 0;
    forever begin
      @(negedge clk);
      if (!$onehot0(grant)) onehotErr++;
      if (rdyHoldLow) begin
        tx_rdy = 1'b0;
      end else if (txCnt > 0) begin
        txCnt--;
        if (txCnt == 0) tx_rdy = 1'b1;
      end else if (tx_en && tx_rdy) begin
        tx_rdy = 1'b0;
        txCnt  = TX_BUSY;
        sent.push_back(tx_data);
      end else begin
        tx_rdy = 1'b1;
      end
    end
  end

  initial begin
    int viol;
    bit seen;
    rst        = 1'b1;
    rdyHoldLow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rqCnt[i]  = 0;
      rqPos[i]  = 0;
      rqLock[i] = 1'b0;
      ackCnt[i] = 0;
      for (int j = 0; j < 4; j++) rqBytes[i][j] = 8'h00;
    end

    repeat (3) @(posedge clk); #1;
    checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single request: one-cycle grant latency, single ack pulse.
    @(posedge clk); #2;
    resetScore();
    applyStimulus(0, 1, 8'h6F, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    checkOutput("single_tx_en", 32'(tx_en), 32'd1);
    checkOutput("single_tx_data", 32'(tx_data), 32'h6F);
    checkOutput("single_grant", 32'(grant), 32'h1);
    checkOutput("single_busy", 32'(busy), 32'd1);
    checkOutput("single_ack_early", 32'(ack), 32'h0);
    @(posedge clk); #1;
    checkOutput("single_ack", 32'(ack), 32'h1);
    checkOutput("single_tx_en_drop", 32'(tx_en), 32'd0);
    @(posedge clk); #1;
    checkOutput("single_ack_pulse", 32'(ack), 32'h0);
    waitDrain("single_drain", 100);
    checkSent("single", 1, 8'h6F, 8'h00, 8'h00, 8'h00);
    checkOutput("single_ack_cnt", 32'(ackCnt[0]), 32'd1);

    // All four at once after reset: requester 0 first, then ascending.
    pulseReset();
    @(posedge clk); #2;
    resetScore();
    applyStimulus(0, 1, 8'h61, 8'h00, 8'h00, 1'b0);
    applyStimulus(1, 1, 8'h62, 8'h00, 8'h00, 1'b0);
    applyStimulus(2, 1, 8'h63, 8'h00, 8'h00, 1'b0);
    applyStimulus(3, 1, 8'h64, 8'h00, 8'h00, 1'b0);
    waitDrain("all4_drain", 200);
    checkSent("all4", 4, 8'h61, 8'h62, 8'h63, 8'h64);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("all4_ack_cnt_%0d", i), 32'(ackCnt[i]), 32'd1);
    end

    // Fairness: ptr is 3, so req1 goes first and req3 gets the next slot.
    @(posedge clk); #2;
    resetScore();
    applyStimulus(1, 3, 8'h11, 8'h12, 8'h13, 1'b0);
    applyStimulus(3, 1, 8'h33, 8'h00, 8'h00, 1'b0);
    waitDrain("fair_drain", 200);
    checkSent("fair", 4, 8'h11, 8'h33, 8'h12, 8'h13);

    // Transmitter not ready: no grant for 1000 cycles, then normal service.
    @(posedge clk); #2;
    resetScore();
    rdyHoldLow = 1'b1;
    @(posedge clk); #2;
    applyStimulus(2, 1, 8'h2A, 8'h00, 8'h00, 1'b0);
    viol = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (tx_en || busy || (grant != '0)) viol++;
    end
    checkOutput("hold_quiet", 32'(viol), 32'd0);
    rdyHoldLow = 1'b0;
    waitDrain("hold_drain", 100);
    checkSent("hold", 1, 8'h2A, 8'h00, 8'h00, 8'h00);

    // Reset while waiting on the transmitter, then full restart from requester 0.
    @(posedge clk); #2;
    resetScore();
    applyStimulus(1, 1, 8'h55, 8'h00, 8'h00, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (ackCnt[1] == 1);
    end
    checkOutput("wrst_ack_seen", 32'(seen), 32'd1);
    checkOutput("wrst_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("wrst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("wrst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("wrst_grant", 32'(grant), 32'h0);
    checkOutput("wrst_busy", 32'(busy), 32'd0);
    checkOutput("wrst_ack", 32'(ack), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      seen = tx_rdy && (txCnt == 0);
    end
    checkOutput("wrst_rdy_back", 32'(seen), 32'd1);
    #1;
    resetScore();
    applyStimulus(0, 1, 8'h71, 8'h00, 8'h00, 1'b0);
    applyStimulus(1, 1, 8'h72, 8'h00, 8'h00, 1'b0);
    applyStimulus(2, 1, 8'h73, 8'h00, 8'h00, 1'b0);
    applyStimulus(3, 1, 8'h74, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("wrst_first_grant", 32'(grant), 32'h1);
    waitDrain("wrst_drain", 200);
    checkSent("wrst", 4, 8'h71, 8'h72, 8'h73, 8'h74);

    // Lock: bring ptr to 1, then req2 (locked, 3 bytes) competes with req0.
    @(posedge clk); #2;
    applyStimulus(1, 1, 8'h5A, 8'h00, 8'h00, 1'b0);
    waitDrain("lock_pre_drain", 100);
    @(posedge clk); #2;
    resetScore();
    applyStimulus(2, 3, 8'hC1, 8'hC2, 8'hC3, 1'b1);
    applyStimulus(0, 1, 8'hA0, 8'h00, 8'h00, 1'b0);
    waitDrain("lock_drain", 200);
`ifdef UART_ARB_LOCK_EN
    checkSent("lock_seq", 4, 8'hC1, 8'hC2, 8'hC3, 8'hA0);
`else
    checkSent("rr_seq", 4, 8'hC1, 8'hA0, 8'hC2, 8'hC3);
`endif
    rqLock[2] = 1'b0;

    checkOutput("grant_onehot", 32'(onehotErr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
